// File: rtl/cpu_if_fifo.sv
// CPU interface tile: two independent show-ahead FIFOs (fabric->top, top->fabric)
// with a config-selected combinational bypass for designs that drive top pins directly.

// Show-ahead FIFO; ready/valid derive from registered level only.
// clr_i empties pointers and level on the next edge; storage is left untouched.
module cpu_if_fifo_buf #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic                 clk_i,
  input  logic                 clr_i,
  input  logic [W-1:0]         in_dat_i,
  input  logic                 in_vld_i,
  output logic                 in_rdy_o,
  output logic [W-1:0]         out_dat_o,
  output logic                 out_vld_o,
  input  logic                 out_rdy_i,
  output logic [$clog2(D):0]   level_o
);

  localparam int PW = $clog2(D);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(D);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  assign in_rdy_o  = (level_q != FULL);
  assign out_vld_o = (level_q != '0);
  assign out_dat_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  assign push = in_vld_i & in_rdy_o;
  assign pop  = out_vld_o & out_rdy_i;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem_q[wr_ptr_q] <= in_dat_i;
  end

endmodule

// Top: F2T and T2F FIFOs, or pure wires when BYPASS is set.
// FIFO latency 1 cycle; bypass has zero latency and passes ready straight through.
module cpu_if_fifo #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 4,
  parameter int NoConfigBits = 1
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [WIDTH-1:0]          I,
  input  logic                      I_valid,
  output logic                      I_ready,
  output logic [WIDTH-1:0]          O,
  output logic                      O_valid,
  input  logic                      O_ready,
  output logic [WIDTH-1:0]          I_top,
  output logic                      I_top_valid,
  input  logic                      I_top_ready,
  input  logic [WIDTH-1:0]          O_top,
  input  logic                      O_top_valid,
  output logic                      O_top_ready,
  output logic [$clog2(DEPTH):0]    F2T_level,
  output logic [$clog2(DEPTH):0]    T2F_level,
  input  logic [NoConfigBits-1:0]   ConfigBits
);

  logic bypass;
  logic clr;

  generate
    if (NoConfigBits > 0) begin : g_cfg
      assign bypass = ConfigBits[0];
    end else begin : g_nocfg
      assign bypass = 1'b0;
    end
  endgenerate

  // Bypass flushes like reset; reset never touches the bypass wires.
  assign clr = ~RESETN | bypass;

  logic [WIDTH-1:0] f2t_dat;
  logic             f2t_vld, f2t_in_rdy;
  logic [WIDTH-1:0] t2f_dat;
  logic             t2f_vld, t2f_in_rdy;

  cpu_if_fifo_buf #(.W(WIDTH), .D(DEPTH)) u_f2t (
    .clk_i     (CLK),
    .clr_i     (clr),
    .in_dat_i  (I),
    .in_vld_i  (I_valid & ~bypass),
    .in_rdy_o  (f2t_in_rdy),
    .out_dat_o (f2t_dat),
    .out_vld_o (f2t_vld),
    .out_rdy_i (I_top_ready & ~bypass),
    .level_o   (F2T_level)
  );

  cpu_if_fifo_buf #(.W(WIDTH), .D(DEPTH)) u_t2f (
    .clk_i     (CLK),
    .clr_i     (clr),
    .in_dat_i  (O_top),
    .in_vld_i  (O_top_valid & ~bypass),
    .in_rdy_o  (t2f_in_rdy),
    .out_dat_o (t2f_dat),
    .out_vld_o (t2f_vld),
    .out_rdy_i (O_ready & ~bypass),
    .level_o   (T2F_level)
  );

  assign I_top       = bypass ? I           : f2t_dat;
  assign I_top_valid = bypass ? I_valid     : f2t_vld;
  assign I_ready     = bypass ? I_top_ready : f2t_in_rdy;
  assign O           = bypass ? O_top       : t2f_dat;
  assign O_valid     = bypass ? O_top_valid : t2f_vld;
  assign O_top_ready = bypass ? O_ready     : t2f_in_rdy;

endmodule
